// File: rtl/mem_trace_buf_pkg.sv
// Shared types and entry layout for the data-memory trace buffer.
// Entry layout (LSB first): addr | data | ld | st | ts (ts only when
// MEM_TRACE_TS_EN is defined).
package mem_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  function automatic int ent_data_lo(int aw);
    return aw;
  endfunction

  function automatic int ent_ld_bit(int aw, int dw);
    return aw + dw;
  endfunction

  function automatic int ent_st_bit(int aw, int dw);
    return aw + dw + 1;
  endfunction

  function automatic int ent_ts_lo(int aw, int dw);
    return aw + dw + 2;
  endfunction

  function automatic int ent_w(int aw, int dw, int tw);
`ifdef MEM_TRACE_TS_EN
    return aw + dw + 2 + tw;
`else
    return aw + dw + 2 + (tw - tw);
`endif
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered 1-cycle read.
// A same-address read/write returns the old contents.
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata read data.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_trace_buf.sv
// Data-memory bus trace capture: snoops loads/stores into a ring buffer,
// stops on an address-match trigger plus a post-trigger count (or when full
// in one-shot mode), then drains oldest-first via rd_en/rd_valid.
// Optional timestamping is enabled by defining MEM_TRACE_TS_EN.
// Ports: clk/rst (sync, active high); bus_* snoop inputs; arm/clear/oneshot
// and trig_addr/trig_mask/post_cnt control; state_o/count_o/wrapped_o/done_o
// status; rd_en pop request with rd_valid and rd_* entry fields.
module mem_trace_buf
  import mem_trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          bus_addr,
  input  logic [DATA_W-1:0]          bus_rdata,
  input  logic [DATA_W-1:0]          bus_wdata,
  input  logic                       bus_ld,
  input  logic                       bus_st,
  input  logic                       arm,
  input  logic                       clear,
  input  logic                       oneshot,
  input  logic [ADDR_W-1:0]          trig_addr,
  input  logic [ADDR_W-1:0]          trig_mask,
  input  logic [$clog2(DEPTH)-1:0]   post_cnt,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       wrapped_o,
  output logic                       done_o,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_ld,
  output logic                       rd_st,
  output logic [TS_W-1:0]            rd_ts
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int EW      = ent_w(ADDR_W, DATA_W, TS_W);
  localparam int DATA_LO = ent_data_lo(ADDR_W);
  localparam int LD_B    = ent_ld_bit(ADDR_W, DATA_W);
  localparam int ST_B    = ent_st_bit(ADDR_W, DATA_W);

  trace_state_e  state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rem_q, rem_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrapped_q, wrapped_d;
  logic          rd_valid_q;
  logic          we, pop, ev, full, hit;
  logic [EW-1:0] ent, ram_q;

  assign ev   = (bus_ld | bus_st) && (state_q == ARMED || state_q == POST);
  assign full = (count_q == CW'(DEPTH));
  assign hit  = ((bus_addr ^ trig_addr) & trig_mask) == '0;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    rem_d     = rem_q;
    we        = 1'b0;
    pop       = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      wrapped_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (arm) begin
          state_d   = ARMED;
          wptr_d    = '0;
          rptr_d    = '0;
          count_d   = '0;
          wrapped_d = 1'b0;
        end
        ARMED, POST: if (ev) begin
          if (oneshot && full) begin
            // one-shot buffer is full: freeze contents instead of writing
            state_d = DONE;
          end else begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (full) begin
              // ring overwrite: the oldest entry is lost, read side follows
              rptr_d    = rptr_q + 1'b1;
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
            if (state_q == ARMED) begin
              if (hit) begin
                rem_d   = post_cnt;
                state_d = (post_cnt == '0) ? DONE : POST;
              end
            end else begin
              rem_d = rem_q - 1'b1;
              if (rem_q == PW'(1)) state_d = DONE;
            end
          end
        end
        DONE: if (rd_en && count_q != '0) begin
          pop     = 1'b1;
          rptr_d  = rptr_q + 1'b1;
          count_d = count_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      rem_q      <= rem_d;
      rd_valid_q <= pop;
    end
  end

  // store data follows the write side when both strobes are set
`ifdef MEM_TRACE_TS_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end
  assign ent   = {ts_q, bus_st, bus_ld, (bus_st ? bus_wdata : bus_rdata), bus_addr};
  assign rd_ts = rd_valid_q ? ram_q[ent_ts_lo(ADDR_W, DATA_W) +: TS_W] : '0;
`else
  assign ent   = {bus_st, bus_ld, (bus_st ? bus_wdata : bus_rdata), bus_addr};
  assign rd_ts = '0;
`endif

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (ent),
    .re    (pop),
    .raddr (rptr_q),
    .rdata (ram_q)
  );

  // RAM output is only meaningful in the cycle after a pop
  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_valid_q ? ram_q[ADDR_W-1:0]          : '0;
  assign rd_data   = rd_valid_q ? ram_q[DATA_LO +: DATA_W]   : '0;
  assign rd_ld     = rd_valid_q & ram_q[LD_B];
  assign rd_st     = rd_valid_q & ram_q[ST_B];
  assign state_o   = state_q;
  assign count_o   = count_q;
  assign wrapped_o = wrapped_q;
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_mem_trace_buf.sv
// Directed bench for mem_trace_buf (DEPTH=8, TS_W=4).
module tb_mem_trace_buf;

  localparam int AW = 32, DW = 32, DEPTH = 8, TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [AW-1:0] bus_addr = '0, trig_addr = '0, trig_mask = '0;
  logic [DW-1:0] bus_rdata = '0, bus_wdata = '0;
  logic          bus_ld = 0, bus_st = 0, arm = 0, clear = 0, oneshot = 0, rd_en = 0;
  logic [2:0]    post_cnt = '0;
  logic [1:0]    state_o;
  logic [3:0]    count_o;
  logic          wrapped_o, done_o, rd_valid, rd_ld, rd_st;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [TW-1:0] rd_ts;

  int checks = 0, errors = 0;

  mem_trace_buf #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_rdata(bus_rdata),
    .bus_wdata(bus_wdata), .bus_ld(bus_ld), .bus_st(bus_st), .arm(arm),
    .clear(clear), .oneshot(oneshot), .trig_addr(trig_addr),
    .trig_mask(trig_mask), .post_cnt(post_cnt), .state_o(state_o),
    .count_o(count_o), .wrapped_o(wrapped_o), .done_o(done_o),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ld(rd_ld), .rd_st(rd_st), .rd_ts(rd_ts)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic ev(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                    input logic ld, input logic st);
    bus_addr = a; bus_wdata = wd; bus_rdata = rdv; bus_ld = ld; bus_st = st;
    step();
    bus_ld = 0; bus_st = 0;
  endtask

  function automatic logic [3:0] ets(input logic [3:0] t);
`ifdef MEM_TRACE_TS_EN
    return t;
`else
    return 4'(t & 4'h0);
`endif
  endfunction

  task automatic pop(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic ld, input logic st, input logic [3:0] ts, input bit cts);
    rd_en = 1; step(); rd_en = 0;
    chk({tag, ".valid"}, rd_valid, 1);
    chk({tag, ".addr"}, rd_addr, a);
    chk({tag, ".data"}, rd_data, d);
    chk({tag, ".flags"}, {rd_ld, rd_st}, {ld, st});
    if (cts) chk({tag, ".ts"}, rd_ts, ets(ts));
  endtask

  task automatic status(input string tag, input logic [1:0] s, input logic [3:0] c,
                        input logic w);
    chk({tag, ".state"}, state_o, s);
    chk({tag, ".count"}, count_o, c);
    chk({tag, ".wrapped"}, wrapped_o, w);
    chk({tag, ".done"}, done_o, s == 2'd3);
  endtask

  initial begin
    // reset state
    step(); step(); rst = 0;
    status("reset", 0, 0, 0);
    chk("reset.rd_valid", rd_valid, 0);

    // ring with trigger
    trig_addr = 32'h100; trig_mask = 32'hFFFF_FFFF; post_cnt = 3'd2; oneshot = 0;
    arm = 1; step(); arm = 0;
    status("ring.armed", 1, 0, 0);
    for (int i = 0; i < 3; i++) ev(32'(i * 4), 32'(i + 'h10), 32'h0, 0, 1);
    rd_en = 1; step(); rd_en = 0;
    chk("ring.rd_armed.valid", rd_valid, 0);
    chk("ring.rd_armed.count", count_o, 3);
    for (int i = 3; i < 8; i++) ev(32'(i * 4), 32'(i + 'h10), 32'h0, 0, 1);
    status("ring.full", 1, 8, 0);
    ev(32'h100, 32'h0, 32'hAA, 1, 0);
    status("ring.trig", 2, 8, 1);
    ev(32'h200, 32'h201, 32'h0, 0, 1);
    status("ring.post1", 2, 8, 1);
    ev(32'h204, 32'h205, 32'h0, 0, 1);
    status("ring.done", 3, 8, 1);
    ev(32'h208, 32'h209, 32'h0, 0, 1);
    status("ring.after", 3, 8, 1);
    pop("ring.r0", 32'h0C, 32'h13, 0, 1, 0, 0);
    pop("ring.r1", 32'h10, 32'h14, 0, 1, 0, 0);
    pop("ring.r2", 32'h14, 32'h15, 0, 1, 0, 0);
    pop("ring.r3", 32'h18, 32'h16, 0, 1, 0, 0);
    pop("ring.r4", 32'h1C, 32'h17, 0, 1, 0, 0);
    pop("ring.r5", 32'h100, 32'hAA, 1, 0, 0, 0);
    pop("ring.r6", 32'h200, 32'h201, 0, 1, 0, 0);
    pop("ring.r7", 32'h204, 32'h205, 0, 1, 0, 0);
    rd_en = 1; step(); rd_en = 0;
    chk("ring.empty.valid", rd_valid, 0);
    status("ring.empty", 3, 0, 1);
    clear = 1; step(); clear = 0;
    status("ring.clear", 0, 0, 0);

    // oneshot full
    oneshot = 1;
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 8; i++) ev(32'(32'h40 + i * 4), 32'(i), 32'h0, 0, 1);
    status("os.full", 1, 8, 0);
    ev(32'h60, 32'h8, 32'h0, 0, 1);
    status("os.done", 3, 8, 0);
    pop("os.r0", 32'h40, 32'h0, 0, 1, 0, 0);
    pop("os.r1", 32'h44, 32'h1, 0, 1, 0, 0);
    clear = 1; step(); clear = 0;
    oneshot = 0;

    // simultaneous ld+st, mask=0 and post_cnt=0
    trig_mask = '0; post_cnt = 3'd0;
    arm = 1; step(); arm = 0;
    ev(32'h80, 32'h55, 32'h66, 1, 1);
    status("ldst.done", 3, 1, 0);
    pop("ldst.r0", 32'h80, 32'h55, 1, 1, 0, 0);
    rd_en = 1; step(); rd_en = 0;
    chk("ldst.empty.valid", rd_valid, 0);
    chk("ldst.empty.count", count_o, 0);
    clear = 1; step(); clear = 0;
    rd_en = 1; step(); rd_en = 0;
    chk("idle.rd.valid", rd_valid, 0);

    // clear together with arm while in POST
    trig_mask = 32'hFFFF_FFFF; post_cnt = 3'd3;
    arm = 1; step(); arm = 0;
    ev(32'h100, 32'h0, 32'h1, 1, 0);
    ev(32'h4, 32'h2, 32'h0, 0, 1);
    status("clr.post", 2, 2, 0);
    clear = 1; arm = 1; step(); clear = 0; arm = 0;
    status("clr.idle", 0, 0, 0);
    step();
    chk("clr.stay", state_o, 0);

    // reset mid-ARMED, then timestamps across the 4-bit wrap
    post_cnt = 3'd1;
    arm = 1; step(); arm = 0;
    ev(32'h300, 32'h1, 32'h0, 0, 1);
    rst = 1; step(); rst = 0;             // ts = 0
    status("rst.armed", 0, 0, 0);
    arm = 1; step(); arm = 0;             // ts = 1
    idle(8);                              // ts = 9
    ev(32'h10, 32'hA, 32'h0, 0, 1);       // 9
    idle(2); ev(32'h14, 32'hB, 32'h0, 0, 1); // 12
    idle(2); ev(32'h18, 32'hC, 32'h0, 0, 1); // 15
    idle(2); ev(32'h100, 32'h0, 32'hD, 1, 0); // 2, trigger
    idle(2); ev(32'h1C, 32'hE, 32'h0, 0, 1); // 5, last post entry
    status("ts.done", 3, 5, 0);
    pop("ts.r0", 32'h10, 32'hA, 0, 1, 4'd9, 1);
    pop("ts.r1", 32'h14, 32'hB, 0, 1, 4'd12, 1);
    pop("ts.r2", 32'h18, 32'hC, 0, 1, 4'd15, 1);
    pop("ts.r3", 32'h100, 32'hD, 1, 0, 4'd2, 1);
    pop("ts.r4", 32'h1C, 32'hE, 0, 1, 4'd5, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_trace_buf.md
Name: mem_trace_buf

Overview:
- Synthesizable data-memory bus trace capture unit. It replaces file-based bench logging of addr, load data, ld, store data and st with an on-chip ring buffer.
- Sits beside the core's dmem port and snoops every load or store with a timestamp.
- Supports an address-match trigger, a post-trigger count and wrap or one-shot modes.
- After capture, the buffer is drained oldest-first over a simple read handshake.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- DEPTH, 64, entries; power of two, ≥4
- TS_W, 16, timestamp counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- bus_addr  in  ADDR_W  dmem address
- bus_rdata  in  DATA_W  data from dmem (valid same cycle as bus_ld)
- bus_wdata  in  DATA_W  data to dmem
- bus_ld  in  1  load strobe
- bus_st  in  1  store strobe
- arm  in  1  start capture (IDLE only)
- clear  in  1  abort/flush to IDLE
- oneshot  in  1  0: ring overwrites oldest; 1: stop when full
- trig_addr  in  ADDR_W  trigger address
- trig_mask  in  ADDR_W  1 = bit compared
- post_cnt  in  $clog2(DEPTH)  entries captured after trigger entry
- state_o  out  2  FSM state
- count_o  out  $clog2(DEPTH)+1  valid entries held
- wrapped_o  out  1  at least one entry overwritten
- done_o  out  1  state == DONE
- rd_en  in  1  pop request
- rd_valid  out  1  rd_* fields valid this cycle
- rd_addr  out  ADDR_W  entry address
- rd_data  out  DATA_W  entry data
- rd_ld  out  1  entry load flag
- rd_st  out  1  entry store flag
- rd_ts  out  TS_W  entry timestamp

Behaviour:
- Reset: state IDLE; write pointer, read pointer, count and timestamp = 0. All outputs 0.
- Timestamp: free-running TS_W counter from reset; wraps silently.
- Capture event: (bus_ld | bus_st) while in ARMED or POST.
  - Entry = {addr, data, ld, st, ts}.
  - data = bus_st ? bus_wdata : bus_rdata.
  - ld and st both high: both flags stored, data = wdata.
- Trigger: capture event in ARMED with ((bus_addr ^ trig_addr) & trig_mask) == 0. trig_mask = 0 triggers on the first event.
- FSM:
  - IDLE → ARMED on arm; pointers and count zeroed.
  - ARMED: capture every event. On trigger, capture that entry and go to POST with remaining = post_cnt. If post_cnt = 0, go directly to DONE.
  - POST: each event captured and remaining decrements. At the event making remaining 0 → DONE.
  - DONE: no capture; drain via rd_en.
  - Any state → IDLE on clear (next cycle, count = 0). Clear dominates arm and rd_en. Arm outside IDLE is ignored.
- Full handling (count == DEPTH):
  - Ring mode: overwrite oldest, advance read pointer, set wrapped_o, count stays DEPTH.
  - Oneshot mode: next event forces DONE without writing.
- post_cnt is sampled at trigger. Because it is DEPTH-1 max, the trigger entry always survives.
- Readout:
  - rd_en in DONE with count > 0: rd_valid high next cycle with the oldest entry; count decrements.
  - rd_en with count = 0 or outside DONE: ignored, rd_valid 0.
  - Back-to-back rd_en sustains one entry per cycle.
  - Remains in DONE when empty, until clear.
- Reset mid-operation is identical to clear; it also zeroes ts.

Optional Feature:
- Macro MEM_TRACE_TS_EN.
- Defined: the timestamp counter exists, ts is stored per entry and rd_ts carries it.
- Undefined: no counter, no ts storage; rd_ts tied 0 and RAM width reduced by TS_W.

Decomposition:
- Package mem_trace_pkg:
  - State enum: IDLE=0, ARMED=1, POST=2, DONE=3.
  - Entry-field offset localparam functions.
- Sub-module trace_ram:
  - Simple dual-port memory, DEPTH × entry width.
  - Registered 1-cycle read, synchronous write.
  - Same-address read/write returns old data (cannot occur by FSM design).

Test Plan:
- Ring with trigger:
  - Setup: DEPTH=8, ring, trig_addr=0x100, mask=0xFFFFFFFF, post_cnt=2.
  - Stimulus: stores to 0x0,0x4,…,0x1C, then ld 0x100 (rdata 0xAA), then 3 more stores.
  - Required: DONE after 2 post entries, count=8, wrapped=1. Readout ends with the 0x100/0xAA/ld entry followed by 2 post entries; third store not captured.
- Oneshot full:
  - Stimulus: oneshot=1, no matching trigger, 9 events.
  - Required: DONE at the 9th event, count=8, wrapped=0, first entry read = first event.
- Simultaneous ld+st:
  - Stimulus: ld=st=1, wdata=0x55, rdata=0x66.
  - Required: entry ld=1, st=1, data=0x55.
- Trigger edge cases:
  - post_cnt=0 with mask=0 → DONE the cycle after the first event; count=1.
  - rd_en while empty → rd_valid=0, count stays 0.
- Clear/reset in POST:
  - Stimulus: clear asserted mid-POST together with arm.
  - Required: IDLE next cycle, count=0. Reset mid-ARMED likewise, plus ts=0 (MEM_TRACE_TS_EN).
- Timestamp:
  - Stimulus: TS_W=4, events 3 cycles apart across the counter wrap.
  - Required: rd_ts sequence wraps 15→2 correctly. Without the macro, rd_ts=0.
